// File: rtl/mb_rx_frame_ctrl_if.sv
// Bus bundle between a UART byte receiver / frame consumer and mb_rx_frame_ctrl.
interface mb_rx_frame_ctrl_if;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       rx_state;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_valid;
  logic [8:0] frame_len;
  logic       frame_bcast;
  logic       frame_ack;
  logic       frame_drop;
  logic       busy;

  // Environment side: feeds received bytes and acknowledges frames.
  modport master (
    output rx_done, rx_data, rx_state, frame_ack,
    input  wr_en, wr_addr, wr_data, frame_valid, frame_len, frame_bcast,
           frame_drop, busy
  );

  // Frame controller side.
  modport slave (
    input  rx_done, rx_data, rx_state, frame_ack,
    output wr_en, wr_addr, wr_data, frame_valid, frame_len, frame_bcast,
           frame_drop, busy
  );
endinterface

// File: rtl/mb_rx_frame_ctrl.sv
// Modbus RTU receive framing: 3.5-character silence delimiting, 1.5-character
// gap checking, buffer write generation and frame address/length qualification.
module mb_rx_frame_ctrl #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter logic [7:0]  SLAVE_ADDR = 8'h01,
  parameter int unsigned MAX_LEN    = 256
) (
  input logic               clk_in,
  input logic               rst_n_in,
  mb_rx_frame_ctrl_if.slave bus
);

  localparam int unsigned BPS     = CLK_FREQ / BAUD_RATE;
  localparam int unsigned DIV_W   = (BPS > 1) ? $clog2(BPS) : 1;
  localparam int unsigned GAP_W   = 6;
  localparam int unsigned LEN_W   = 9;
  localparam int unsigned MIN_LEN = 4;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BPS - 1);
  localparam logic [GAP_W-1:0] GAP_SIL  = GAP_W'(35);
  localparam logic [GAP_W-1:0] GAP_LATE = GAP_W'(15);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(MIN_LEN);

  typedef enum logic [2:0] {
    WAIT_SIL,
    IDLE,
    RECEIVE,
    CHECK,
    HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [LEN_W-1:0] len_q, len_d;
  logic             err_q, err_d;
  logic [7:0]       byte0_q, byte0_d;
  logic             wr_en_q, wr_en_d;
  logic [7:0]       wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             frame_valid_q, frame_valid_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic             frame_bcast_q, frame_bcast_d;
  logic             frame_drop_q, frame_drop_d;
  logic             busy_q, busy_d;

  logic silence_c;
  logic late_c;
  logic addr_ok_c;

  assign silence_c = (gap_cnt == GAP_SIL);
  assign late_c    = (gap_cnt >= GAP_LATE);
  assign addr_ok_c = (byte0_q == SLAVE_ADDR) || (byte0_q == 8'h00);

  // Bit-period gap timer; restarts on every byte and while a character is in flight.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      div_cnt <= '0;
      gap_cnt <= '0;
    end else if (bus.rx_done || bus.rx_state) begin
      div_cnt <= '0;
      gap_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      if (gap_cnt != GAP_SIL) gap_cnt <= gap_cnt + GAP_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // State, frame bookkeeping and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= WAIT_SIL;
      len_q         <= '0;
      err_q         <= 1'b0;
      byte0_q       <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_len_q   <= '0;
      frame_bcast_q <= 1'b0;
      frame_drop_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      err_q         <= err_d;
      byte0_q       <= byte0_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_valid_q <= frame_valid_d;
      frame_len_q   <= frame_len_d;
      frame_bcast_q <= frame_bcast_d;
      frame_drop_q  <= frame_drop_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    err_d         = err_q;
    byte0_d       = byte0_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_valid_d = frame_valid_q;
    frame_len_d   = frame_len_q;
    frame_bcast_d = frame_bcast_q;
    frame_drop_d  = 1'b0;

    case (state_q)
      WAIT_SIL: begin
        if (silence_c) state_d = IDLE;
      end
      IDLE: begin
        if (bus.rx_done) begin
          wr_en_d   = 1'b1;
          wr_addr_d = 8'h00;
          wr_data_d = bus.rx_data;
          byte0_d   = bus.rx_data;
          len_d     = LEN_W'(1);
          err_d     = 1'b0;
          state_d   = RECEIVE;
        end
      end
      RECEIVE: begin
        if (bus.rx_done) begin
          // A late byte is still stored; only the frame is marked bad.
          if (late_c) err_d = 1'b1;
          if (len_q < LEN_MAX) begin
            wr_en_d   = 1'b1;
            wr_addr_d = len_q[7:0];
            wr_data_d = bus.rx_data;
            len_d     = len_q + LEN_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end else if (silence_c) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (err_q || (len_q < LEN_MIN) || !addr_ok_c) begin
          frame_drop_d = 1'b1;
          // A byte landing here starts an unframed sequence; resync on silence.
          state_d      = bus.rx_done ? WAIT_SIL : IDLE;
        end else begin
          frame_valid_d = 1'b1;
          frame_len_d   = len_q;
          frame_bcast_d = (byte0_q == 8'h00);
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (bus.frame_ack) begin
          frame_valid_d = 1'b0;
          frame_len_d   = '0;
          frame_bcast_d = 1'b0;
          state_d       = WAIT_SIL;
        end
      end
      default: state_d = WAIT_SIL;
    endcase

    busy_d = (state_d == RECEIVE) || (state_d == CHECK) || (state_d == HOLD);
  end

  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_len   = frame_len_q;
  assign bus.frame_bcast = frame_bcast_q;
  assign bus.frame_drop  = frame_drop_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_mb_rx_frame_ctrl.sv
// Directed bench for mb_rx_frame_ctrl at BPS=10 (3.5T = 350 cycles).
// Two instances share stimulus: A with MAX_LEN=256, B with MAX_LEN=4.
module tb_mb_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       rx_state;
  logic       frame_ack;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mb_rx_frame_ctrl_if bus_a ();
  mb_rx_frame_ctrl_if bus_b ();

  assign bus_a.rx_done   = rx_done;
  assign bus_a.rx_data   = rx_data;
  assign bus_a.rx_state  = rx_state;
  assign bus_a.frame_ack = frame_ack;
  assign bus_b.rx_done   = rx_done;
  assign bus_b.rx_data   = rx_data;
  assign bus_b.rx_state  = rx_state;
  assign bus_b.frame_ack = frame_ack;

  mb_rx_frame_ctrl #(
    .CLK_FREQ(1000), .BAUD_RATE(100), .SLAVE_ADDR(8'h01), .MAX_LEN(256)
  ) u_dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .bus(bus_a.slave)
  );

  mb_rx_frame_ctrl #(
    .CLK_FREQ(1000), .BAUD_RATE(100), .SLAVE_ADDR(8'h01), .MAX_LEN(4)
  ) u_dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .bus(bus_b.slave)
  );

  // Output monitors, sampled on the falling edge.
  int         a_wr_cnt = 0, b_wr_cnt = 0;
  int         a_drop_cnt = 0, b_drop_cnt = 0;
  int         a_valid_rise = 0;
  int         drop_run = 0, drop_max = 0;
  logic       a_valid_prev = 1'b0;
  logic [7:0] a_addr_log [64];
  logic [7:0] a_data_log [64];
  logic [7:0] b_addr_log [64];

  always @(negedge clk) begin
    if (bus_a.wr_en === 1'b1) begin
      if (a_wr_cnt < 64) begin
        a_addr_log[a_wr_cnt] = bus_a.wr_addr;
        a_data_log[a_wr_cnt] = bus_a.wr_data;
      end
      a_wr_cnt++;
    end
    if (bus_b.wr_en === 1'b1) begin
      if (b_wr_cnt < 64) b_addr_log[b_wr_cnt] = bus_b.wr_addr;
      b_wr_cnt++;
    end
    if (bus_a.frame_drop === 1'b1) begin
      a_drop_cnt++;
      drop_run++;
      if (drop_run > drop_max) drop_max = drop_run;
    end else begin
      drop_run = 0;
    end
    if (bus_b.frame_drop === 1'b1) b_drop_cnt++;
    if ((bus_a.frame_valid === 1'b1) && !a_valid_prev) a_valid_rise++;
    a_valid_prev = (bus_a.frame_valid === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One received byte, rx_done pulses spaced 'spacing' cycles apart.
  task automatic send_byte(input logic [7:0] d, input int spacing);
    repeat (spacing - 1) @(negedge clk);
    rx_data = d;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send4(input logic [7:0] b0, b1, b2, b3, input int first);
    send_byte(b0, first);
    send_byte(b1, 100);
    send_byte(b2, 100);
    send_byte(b3, 100);
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
  endtask

  int         wb, bb, db, dbb, vb;
  logic [7:0] exp_d [4];

  initial begin
    rst_n     = 1'b0;
    rx_done   = 1'b0;
    rx_data   = 8'h00;
    rx_state  = 1'b0;
    frame_ack = 1'b0;

    // Reset values
    idle(3);
    check("rst_wr_en",  32'(bus_a.wr_en), 0);
    check("rst_valid",  32'(bus_a.frame_valid), 0);
    check("rst_len",    32'(bus_a.frame_len), 0);
    check("rst_busy",   32'(bus_a.busy), 0);
    check("rst_drop",   32'(bus_a.frame_drop), 0);
    rst_n = 1'b1;
    idle(360);

    // Unicast frame to own address
    wb = a_wr_cnt; db = a_drop_cnt;
    exp_d[0] = 8'h01; exp_d[1] = 8'h03; exp_d[2] = 8'h00; exp_d[3] = 8'h00;
    send4(exp_d[0], exp_d[1], exp_d[2], exp_d[3], 100);
    idle(400);
    check("uni_wr_cnt", 32'(a_wr_cnt - wb), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("uni_addr%0d", i), 32'(a_addr_log[wb + i]), 32'(i));
      check($sformatf("uni_data%0d", i), 32'(a_data_log[wb + i]), 32'(exp_d[i]));
    end
    check("uni_valid", 32'(bus_a.frame_valid), 1);
    check("uni_len",   32'(bus_a.frame_len), 4);
    check("uni_bcast", 32'(bus_a.frame_bcast), 0);
    check("uni_busy",  32'(bus_a.busy), 1);
    check("uni_drop",  32'(a_drop_cnt - db), 0);
    ack();
    check("uni_ack_valid", 32'(bus_a.frame_valid), 0);
    check("uni_ack_busy",  32'(bus_a.busy), 0);

    // Broadcast frame
    idle(5);
    send4(8'h00, 8'h06, 8'h00, 8'h01, 100);
    idle(400);
    check("bc_valid", 32'(bus_a.frame_valid), 1);
    check("bc_bcast", 32'(bus_a.frame_bcast), 1);
    check("bc_len",   32'(bus_a.frame_len), 4);
    ack();

    // Foreign address dropped; following frame accepted straight from IDLE
    idle(5);
    db = a_drop_cnt; vb = a_valid_rise;
    send4(8'h02, 8'h03, 8'h00, 8'h00, 100);
    idle(400);
    check("foreign_drop",  32'(a_drop_cnt - db), 1);
    check("foreign_valid", 32'(a_valid_rise - vb), 0);
    check("foreign_busy",  32'(bus_a.busy), 0);
    send4(8'h01, 8'h03, 8'h00, 8'h01, 20);
    idle(400);
    check("after_drop_valid", 32'(bus_a.frame_valid), 1);
    ack();

    // 1.5-character violation: bytes stored, frame dropped
    idle(5);
    wb = a_wr_cnt; db = a_drop_cnt; vb = a_valid_rise;
    send_byte(8'h01, 100);
    send_byte(8'h03, 100);
    send_byte(8'h00, 200);
    send_byte(8'h00, 100);
    idle(400);
    check("late_wr_cnt", 32'(a_wr_cnt - wb), 4);
    check("late_drop",   32'(a_drop_cnt - db), 1);
    check("late_valid",  32'(a_valid_rise - vb), 0);

    // Five bytes: B (MAX_LEN=4) overflows, A accepts length 5
    bb = b_wr_cnt; dbb = b_drop_cnt;
    send4(8'h01, 8'h03, 8'h00, 8'h00, 100);
    send_byte(8'h00, 100);
    idle(400);
    check("ovf_b_wr_cnt",   32'(b_wr_cnt - bb), 4);
    check("ovf_b_last_addr", 32'(b_addr_log[bb + 3]), 3);
    check("ovf_b_drop",     32'(b_drop_cnt - dbb), 1);
    check("ovf_a_len",      32'(bus_a.frame_len), 5);
    ack();

    // Bytes arriving while a frame is held are not written
    idle(400);
    send4(8'h01, 8'h03, 8'h00, 8'h00, 100);
    idle(400);
    wb = a_wr_cnt;
    send_byte(8'h11, 100);
    send_byte(8'h22, 100);
    idle(10);
    check("hold_wr_cnt", 32'(a_wr_cnt - wb), 0);
    check("hold_valid",  32'(bus_a.frame_valid), 1);
    check("hold_len",    32'(bus_a.frame_len), 4);
    ack();

    // Reset mid-frame, then silence required before the next acceptance
    idle(400);
    send_byte(8'h01, 100);
    send_byte(8'h03, 100);
    check("mid_busy", 32'(bus_a.busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  32'(bus_a.busy), 0);
    check("mid_rst_wr_en", 32'(bus_a.wr_en), 0);
    idle(3);
    rst_n = 1'b1;
    rx_state = 1'b1;
    idle(400);
    rx_state = 1'b0;
    wb = a_wr_cnt;
    send_byte(8'h01, 300);
    idle(5);
    check("sil_blocked_wr", 32'(a_wr_cnt - wb), 0);
    check("sil_blocked_busy", 32'(bus_a.busy), 0);
    wb = a_wr_cnt;
    send4(8'h01, 8'h03, 8'h00, 8'h00, 360);
    idle(400);
    check("sil_ok_wr_cnt", 32'(a_wr_cnt - wb), 4);
    check("sil_ok_valid",  32'(bus_a.frame_valid), 1);
    ack();

    check("drop_width", 32'(drop_max), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
